// File: rtl/apu_mixer_sd_pkg.sv
// Shared constants and types for the APU output mixer / sigma-delta path.
package apu_mixer_sd_pkg;
  localparam int CH_WIDTH       = 4;
  localparam int LEVEL_WIDTH    = 9;
  localparam int GAIN_WIDTH     = 9;
  localparam int GAIN_MAX       = 256;
  localparam int P_WEIGHT_DEF   = 6;
  localparam int T_WEIGHT_DEF   = 5;
  localparam int N_WEIGHT_DEF   = 3;
  localparam int FULL_SCALE_DEF = 300;
  localparam int RAMP_STEP_DEF  = 1;

  localparam int CH_P1    = 0;
  localparam int CH_P2    = 1;
  localparam int CH_TRI   = 2;
  localparam int CH_NOISE = 3;

  typedef logic [CH_WIDTH-1:0]    ch_t;
  typedef logic [LEVEL_WIDTH-1:0] level_t;
  typedef logic [GAIN_WIDTH-1:0]  gain_t;

  typedef struct packed {
    ch_t noise;
    ch_t tri_lvl;
    ch_t p2;
    ch_t p1;
  } chans_t;
endpackage

// File: rtl/apu_mixer_sd_if.sv
// Channel levels in, audio bitstream and debug level out. mute_mask exists only with MIXER_MUTE_EN.
interface apu_mixer_sd_if;
  import apu_mixer_sd_pkg::*;

  logic   enable_240hz;
  ch_t    pulse1_in;
  ch_t    pulse2_in;
  ch_t    tri_in;
  ch_t    noise_in;
`ifdef MIXER_MUTE_EN
  logic [3:0] mute_mask;
`endif
  logic   pdm_out;
  level_t level;
  logic   ramp_done;

  modport master (
    output enable_240hz, pulse1_in, pulse2_in, tri_in, noise_in,
`ifdef MIXER_MUTE_EN
    output mute_mask,
`endif
    input  pdm_out, level, ramp_done
  );

  modport slave (
    input  enable_240hz, pulse1_in, pulse2_in, tri_in, noise_in,
`ifdef MIXER_MUTE_EN
    input  mute_mask,
`endif
    output pdm_out, level, ramp_done
  );
endinterface

// File: rtl/apu_mixer_sd_sd_modulator_1st.sv
// First-order sigma-delta modulator: ones density on pdm_o equals level_i / FULL_SCALE.
module sd_modulator_1st #(
  parameter int LEVEL_W    = 9,
  parameter int FULL_SCALE = 300
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LEVEL_W-1:0] level_i,
  output logic               pdm_o
);
  localparam int SUM_W = LEVEL_W + 1;

  logic [LEVEL_W-1:0] acc_d, acc_q;
  logic [SUM_W-1:0]   sum;
  logic               pdm_d, pdm_q;

  // acc stays below FULL_SCALE, so a single conditional subtract keeps it bounded
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, level_i};
    pdm_d = 1'b0;
    acc_d = acc_q;
    if (sum >= SUM_W'(FULL_SCALE)) begin
      pdm_d = 1'b1;
      acc_d = LEVEL_W'(sum - SUM_W'(FULL_SCALE));
    end else begin
      acc_d = LEVEL_W'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pdm_q <= pdm_d;
    end
  end

  assign pdm_o = pdm_q;
endmodule

// File: rtl/apu_mixer_sd.sv
// Weighted channel mix, power-on gain ramp and sigma-delta output for the APU audio pin.
// Optional per-channel muting is built when MIXER_MUTE_EN is defined.
module apu_mixer_sd
  import apu_mixer_sd_pkg::*;
#(
  parameter int P_WEIGHT   = P_WEIGHT_DEF,
  parameter int T_WEIGHT   = T_WEIGHT_DEF,
  parameter int N_WEIGHT   = N_WEIGHT_DEF,
  parameter int FULL_SCALE = FULL_SCALE_DEF,
  parameter int RAMP_STEP  = RAMP_STEP_DEF
) (
  input  logic           apu_clk,
  input  logic           rst_n,
  apu_mixer_sd_if.slave  bus
);
  if (FULL_SCALE != 30*P_WEIGHT + 15*T_WEIGHT + 15*N_WEIGHT) begin : g_fs_check
    $error("FULL_SCALE does not match the channel weights");
  end

  function automatic level_t mix_fn(input chans_t c);
    logic [31:0] s;
    s = 32'(P_WEIGHT) * (32'(c.p1) + 32'(c.p2))
      + 32'(T_WEIGHT) * 32'(c.tri_lvl)
      + 32'(N_WEIGHT) * 32'(c.noise);
    return level_t'(s);
  endfunction

  function automatic level_t scale_fn(input level_t mix, input gain_t gain);
    logic [LEVEL_WIDTH+GAIN_WIDTH-1:0] prod;
    prod = {{GAIN_WIDTH{1'b0}}, mix} * {{LEVEL_WIDTH{1'b0}}, gain};
    return level_t'(prod >> 8);
  endfunction

  function automatic gain_t sat_gain(input gain_t gain);
    logic [GAIN_WIDTH:0] s;
    s = {1'b0, gain} + (GAIN_WIDTH+1)'(RAMP_STEP);
    return (s >= (GAIN_WIDTH+1)'(GAIN_MAX)) ? gain_t'(GAIN_MAX) : gain_t'(s);
  endfunction

  chans_t ch_p1_d, ch_p1_q;
  level_t mix_p2_d, mix_p2_q;
  level_t level_p3_d, level_p3_q;
  gain_t  gain_d, gain_q;
  logic   ramp_done_d, ramp_done_q;
  logic   pdm;

  // stage 1: capture (and optionally mute) channel levels
  always_comb begin
    ch_p1_d.p1      = bus.pulse1_in;
    ch_p1_d.p2      = bus.pulse2_in;
    ch_p1_d.tri_lvl = bus.tri_in;
    ch_p1_d.noise   = bus.noise_in;
`ifdef MIXER_MUTE_EN
    if (bus.mute_mask[CH_P1])    ch_p1_d.p1      = '0;
    if (bus.mute_mask[CH_P2])    ch_p1_d.p2      = '0;
    if (bus.mute_mask[CH_TRI])   ch_p1_d.tri_lvl = '0;
    if (bus.mute_mask[CH_NOISE]) ch_p1_d.noise   = '0;
`endif
  end

  // stage 2: weighted mix; stage 3: soft-start gain
  always_comb begin
    mix_p2_d   = mix_fn(ch_p1_q);
    level_p3_d = scale_fn(mix_p2_q, gain_q);
  end

  always_comb begin
    gain_d = gain_q;
    if (bus.enable_240hz && (gain_q < gain_t'(GAIN_MAX))) gain_d = sat_gain(gain_q);
    ramp_done_d = ramp_done_q | (gain_d == gain_t'(GAIN_MAX));
  end

  always_ff @(posedge apu_clk) begin
    if (!rst_n) begin
      ch_p1_q     <= '0;
      mix_p2_q    <= '0;
      level_p3_q  <= '0;
      gain_q      <= '0;
      ramp_done_q <= 1'b0;
    end else begin
      ch_p1_q     <= ch_p1_d;
      mix_p2_q    <= mix_p2_d;
      level_p3_q  <= level_p3_d;
      gain_q      <= gain_d;
      ramp_done_q <= ramp_done_d;
    end
  end

  // stage 4: sigma-delta to the pin
  sd_modulator_1st #(
    .LEVEL_W    (LEVEL_WIDTH),
    .FULL_SCALE (FULL_SCALE)
  ) u_sd (
    .clk     (apu_clk),
    .rst_n   (rst_n),
    .level_i (level_p3_q),
    .pdm_o   (pdm)
  );

  assign bus.pdm_out   = pdm;
  assign bus.level     = level_p3_q;
  assign bus.ramp_done = ramp_done_q;
endmodule

// File: tb/tb_apu_mixer_sd.sv
// Scoreboard bench for apu_mixer_sd: randomized channel levels against an arithmetic reference.
module tb_apu_mixer_sd;
  localparam int PW   = 6;
  localparam int TW   = 5;
  localparam int NW   = 3;
  localparam int FS   = 300;
  localparam int STEP = 1;

  logic apu_clk = 1'b0;
  logic rst_n   = 1'b0;

  apu_mixer_sd_if bus();

  apu_mixer_sd dut (
    .apu_clk (apu_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 apu_clk = ~apu_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int model_gain = 0;

  typedef struct {
    int due;
    int lvl;
  } exp_t;
  exp_t sb[$];

  always @(posedge apu_clk) cyc <= cyc + 1;

  function automatic int ref_level(int p1, int p2, int t, int n, logic [3:0] mask, int gain);
    int mix;
    if (mask[0]) p1 = 0;
    if (mask[1]) p2 = 0;
    if (mask[2]) t  = 0;
    if (mask[3]) n  = 0;
    mix = PW * (p1 + p2) + TW * t + NW * n;
    return (mix * gain) / 256;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int n, input int lvl);
    // ones over n cycles must be within one of n*lvl/FS because the accumulator stays in [0,FS)
    checks++;
    if (!((act * FS > n * lvl - FS) && (act * FS < n * lvl + FS))) begin
      errors++;
      $display("FAIL %s: got %0d ones in %0d cycles, expected about %0d*%0d/%0d", name, act, n, n, lvl, FS);
    end
  endtask

  // monitor: level is presented every cycle; compare whatever expectation is due now
  always @(negedge apu_clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      check("level_missed", cyc, e.due);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("level_sb", int'(bus.level), e.lvl);
    end
  end

  task automatic step();
    @(posedge apu_clk);
    #1;
  endtask

  task automatic drive(input int p1, input int p2, input int t, input int n,
                       input logic [3:0] mask, input bit push);
    bus.pulse1_in = 4'(p1);
    bus.pulse2_in = 4'(p2);
    bus.tri_in    = 4'(t);
    bus.noise_in  = 4'(n);
`ifdef MIXER_MUTE_EN
    bus.mute_mask = mask;
`else
    mask = 4'b0000;
`endif
    if (push) sb.push_back('{cyc + 3, ref_level(p1, p2, t, n, mask, model_gain)});
    step();
  endtask

  task automatic tick();
    bus.enable_240hz = 1'b1;
    step();
    bus.enable_240hz = 1'b0;
    model_gain = (model_gain + STEP > 256) ? 256 : model_gain + STEP;
  endtask

  task automatic count_ones(input int p1, input int p2, input int t, input int n,
                            input int len, output int ones);
    ones = 0;
    for (int i = 0; i < len; i++) begin
      drive(p1, p2, t, n, 4'b0000, 1'b1);
      if (bus.pdm_out) ones++;
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ones;
    int lp1, lp2, lt, ln, lvl;

    bus.enable_240hz = 1'b1;
    bus.pulse1_in = 4'd15;
    bus.pulse2_in = 4'd15;
    bus.tri_in    = 4'd15;
    bus.noise_in  = 4'd15;
`ifdef MIXER_MUTE_EN
    bus.mute_mask = 4'b0000;
`endif
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_level", int'(bus.level), 0);
      check("rst_pdm", int'(bus.pdm_out), 0);
      check("rst_ramp_done", int'(bus.ramp_done), 0);
    end
    rst_n = 1'b1;
    bus.enable_240hz = 1'b0;
    model_gain = 0;

    // partial ramp, then a mid-stream reset
    for (int i = 0; i < 100; i++) tick();
    check("midramp_done", int'(bus.ramp_done), 0);
    for (int i = 0; i < 6; i++) drive(15, 15, 0, 0, 4'b0000, 1'b1);
    check("midramp_level", int'(bus.level), 70);
    for (int i = 0; i < 4; i++) drive(15, 15, 0, 0, 4'b0000, 1'b0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_gain = 0;
    check("rstpulse_level", int'(bus.level), 0);
    check("rstpulse_pdm", int'(bus.pdm_out), 0);
    for (int i = 0; i < 3; i++) begin
      drive(15, 15, 0, 0, 4'b0000, 1'b1);
      check("rstpulse_level_hold", int'(bus.level), 0);
      check("rstpulse_done_hold", int'(bus.ramp_done), 0);
    end

    // full ramp from zero; done must rise exactly on tick 256
    for (int i = 1; i <= 256; i++) begin
      tick();
      check("ramp_done_edge", int'(bus.ramp_done), (i == 256) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) tick();
    check("ramp_done_stays", int'(bus.ramp_done), 1);

    for (int i = 0; i < 5; i++) drive(15, 15, 15, 15, 4'b0000, 1'b1);
    check("full_level", int'(bus.level), FS);
    count_ones(15, 15, 15, 15, 200, ones);
    check("full_pdm_ones", ones, 200);

    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), 4'($urandom_range(0, 15)), 1'b1);

    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 4'b0000, 1'b1);
    count_ones(0, 0, 0, 0, 1000, ones);
    check("silence_ones", ones, 0);

    for (int i = 0; i < 10; i++) drive(15, 0, 0, 0, 4'b0000, 1'b1);
    check("p1_level", int'(bus.level), 90);
    count_ones(15, 0, 0, 0, 1000, ones);
    check("p1_density", ones, 300);

    for (int i = 0; i < 10; i++) drive(0, 0, 6, 0, 4'b0000, 1'b1);
    check("tri_level", int'(bus.level), 30);
    count_ones(0, 0, 6, 0, 1000, ones);
    check("tri_density", ones, 100);

    for (int r = 0; r < 4; r++) begin
      lp1 = $urandom_range(0, 15);
      lp2 = $urandom_range(0, 15);
      lt  = $urandom_range(0, 15);
      ln  = $urandom_range(0, 15);
      lvl = ref_level(lp1, lp2, lt, ln, 4'b0000, 256);
      for (int i = 0; i < 6; i++) drive(lp1, lp2, lt, ln, 4'b0000, 1'b1);
      count_ones(lp1, lp2, lt, ln, 600, ones);
      check_range("rand_density", ones, 600, lvl);
    end

`ifdef MIXER_MUTE_EN
    for (int i = 0; i < 6; i++) drive(15, 15, 15, 15, 4'b0011, 1'b1);
    check("mute_level", int'(bus.level), 120);
    for (int i = 0; i < 6; i++) drive(15, 15, 15, 15, 4'b0000, 1'b1);
    check("unmute_level", int'(bus.level), FS);
`endif

    for (int i = 0; i < 5; i++) step();
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
